// File: rtl/uart_tx.sv
// 8N1/8E1/8O1 UART transmitter, one bit per CLK period, registered TX_OUT.
// Optional one-entry hold buffer for back-to-back frames: define UART_TX_HOLD_BUF_EN.
module uart_tx (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] P_DATA,
  input  logic       Data_Valid,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  output logic       TX_OUT,
  output logic       busy,
  output logic       ready
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t     state;
  logic [7:0] data_q;
  logic       par_en_q;
  logic       par_bit_q;
  logic [2:0] bit_cnt;

  logic       accept;
  logic       in_par_bit;
  logic       start_frame;
  logic [7:0] src_data;
  logic       src_par_en;
  logic       src_par_bit;

  assign in_par_bit = (^P_DATA) ^ PAR_TYP;
  assign accept     = Data_Valid & ready;

`ifdef UART_TX_HOLD_BUF_EN
  logic [7:0] hold_data;
  logic       hold_par_en;
  logic       hold_par_bit;
  logic       hold_full;
  logic       load_new;
  logic       load_hold;
  logic       fill_hold;

  assign ready = ~hold_full;

  // A new request goes straight to the shifter when the line is free (IDLE,
  // or STOP with nothing queued); otherwise it is parked in the buffer.
  assign load_hold   = (state == STOP) && hold_full;
  assign load_new    = accept && ((state == IDLE) || ((state == STOP) && !hold_full));
  assign fill_hold   = accept && !load_new;
  assign start_frame = load_new | load_hold;
  assign src_data    = load_hold ? hold_data    : P_DATA;
  assign src_par_en  = load_hold ? hold_par_en  : PAR_EN;
  assign src_par_bit = load_hold ? hold_par_bit : in_par_bit;

  // NOTE: the buffer payload is reset as well, so a cleared buffer never
  // carries stale data even though hold_full alone would gate its use.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hold_full    <= 1'b0;
      hold_data    <= '0;
      hold_par_en  <= 1'b0;
      hold_par_bit <= 1'b0;
    end else begin
      if (load_hold) begin
        hold_full <= fill_hold;
      end else if (fill_hold) begin
        hold_full <= 1'b1;
      end
      if (fill_hold) begin
        hold_data    <= P_DATA;
        hold_par_en  <= PAR_EN;
        hold_par_bit <= in_par_bit;
      end
    end
  end
`else
  assign ready       = ~busy;
  assign start_frame = accept;
  assign src_data    = P_DATA;
  assign src_par_en  = PAR_EN;
  assign src_par_bit = in_par_bit;
`endif

  // NOTE: all state and outputs update with non-blocking assignments so every
  // branch reads the pre-edge values of state, bit_cnt and data_q.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      TX_OUT    <= 1'b1;
      busy      <= 1'b0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      bit_cnt   <= '0;
    end else begin
      case (state)
        IDLE, STOP: begin
          if (start_frame) begin
            state     <= START;
            TX_OUT    <= 1'b0;
            busy      <= 1'b1;
            data_q    <= src_data;
            par_en_q  <= src_par_en;
            par_bit_q <= src_par_bit;
          end else begin
            state  <= IDLE;
            TX_OUT <= 1'b1;
            busy   <= 1'b0;
          end
        end
        START: begin
          state   <= DATA;
          TX_OUT  <= data_q[0];
          bit_cnt <= '0;
        end
        DATA: begin
          if (bit_cnt == 3'd7) begin
            bit_cnt <= '0;
            state   <= par_en_q ? PARITY : STOP;
            TX_OUT  <= par_en_q ? par_bit_q : 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            TX_OUT  <= data_q[bit_cnt + 3'd1];
          end
        end
        PARITY: begin
          state  <= STOP;
          TX_OUT <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          TX_OUT  <= 1'b1;
          busy    <= 1'b0;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed frames plus randomized traffic
// compared bit-by-bit against a frame-level reference model.
module tb_uart_tx;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] P_DATA = '0;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       TX_OUT;
  logic       busy;
  logic       ready;

  int n_cmp = 0;
  int n_bad = 0;
  bit exp_q[$];

  uart_tx dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .busy       (busy),
    .ready      (ready)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference frame: start 0, eight data bits LSB first, optional parity, stop 1.
  function automatic void push_frame(input logic [7:0] d, input logic pe, input logic pt);
    int ones;
    ones = $countones(d);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (pe) exp_q.push_back(pt ? (ones % 2 == 0) : (ones % 2 == 1));
    exp_q.push_back(1'b1);
  endfunction

  // Called on the negedge right after accept; walks exp_q one bit per cycle.
  // garbage_at >= 0 pulses a stray request (0x3C) at that bit index.
  task automatic run_frame(input string tag, input int garbage_at);
    int i = 0;
    while (exp_q.size() > 0) begin
      bit b;
      b = exp_q.pop_front();
      check({tag, "_tx"}, TX_OUT, b);
      check({tag, "_busy"}, busy, 1);
      if (i == garbage_at) begin
        Data_Valid = 1'b1;
        P_DATA     = 8'h3C;
      end else begin
        Data_Valid = 1'b0;
      end
      i++;
      @(negedge CLK);
    end
    Data_Valid = 1'b0;
    check({tag, "_idle_tx"}, TX_OUT, 1);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_ready"}, ready, 1);
  endtask

  // Starts on a negedge; if exp_q was pre-loaded it is used as the expectation.
  task automatic send(input string tag, input logic [7:0] d, input logic pe,
                      input logic pt, input int garbage_at);
    check({tag, "_ready"}, ready, 1);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    P_DATA = ~d; PAR_EN = ~pe; PAR_TYP = ~pt;
    if (exp_q.size() == 0) push_frame(d, pe, pt);
    run_frame(tag, garbage_at);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    check("rst_tx", TX_OUT, 1);
    check("rst_busy", busy, 0);
    check("rst_ready", ready, 1);
    RST = 1'b1;

    // 0xA5 without parity, expectation written out literally.
    exp_q = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    send("a5_np", 8'hA5, 1'b0, 1'b0, -1);

    send("a5_even", 8'hA5, 1'b1, 1'b0, -1);
    send("a5_odd", 8'hA5, 1'b1, 1'b1, -1);
    send("zero_odd", 8'h00, 1'b1, 1'b1, -1);

`ifndef UART_TX_HOLD_BUF_EN
    send("ignore_mid", 8'h81, 1'b0, 1'b0, 4);
    send("ignore_stop", 8'h18, 1'b1, 1'b0, 10);
`endif

    // Reset during data bit 4 of 0xFF.
    P_DATA = 8'hFF; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("ff_pre_tx", TX_OUT, (i == 0) ? 0 : 1);
      @(negedge CLK);
    end
    #2 RST = 1'b0;
    #1;
    check("ff_rst_tx", TX_OUT, 1);
    check("ff_rst_busy", busy, 0);
    check("ff_rst_ready", ready, 1);
    @(negedge CLK);
    check("ff_rst_hold_tx", TX_OUT, 1);
    RST = 1'b1;
    send("ff_after_rst", 8'hFF, 1'b1, 1'b0, -1);

`ifdef UART_TX_HOLD_BUF_EN
    // 0x55 then 0xAA back-to-back; a third request while full is dropped.
    P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    @(negedge CLK);
    push_frame(8'h55, 1'b0, 1'b0);
    push_frame(8'hAA, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      bit b;
      b = exp_q.pop_front();
      check("b2b_tx", TX_OUT, b);
      check("b2b_busy", busy, 1);
      if (i == 0) begin
        check("b2b_ready_empty", ready, 1);
        P_DATA = 8'hAA; Data_Valid = 1'b1;
      end else if (i == 1) begin
        check("b2b_ready_full", ready, 0);
        P_DATA = 8'h3C; Data_Valid = 1'b1;
      end else if (i >= 8) begin
        Data_Valid = 1'b0;
        P_DATA = 8'h00;
      end
      @(negedge CLK);
    end
    check("b2b_idle_tx", TX_OUT, 1);
    check("b2b_idle_busy", busy, 0);
    check("b2b_idle_ready", ready, 1);
`endif

    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      logic pe, pt;
      int g;
      d  = 8'($urandom);
      pe = 1'($urandom);
      pt = 1'($urandom);
`ifdef UART_TX_HOLD_BUF_EN
      g = -1;
`else
      g = $urandom_range(0, pe ? 10 : 9);
`endif
      send("rand", d, pe, pt, g);
      repeat ($urandom_range(0, 2)) begin
        @(negedge CLK);
        check("rand_gap_tx", TX_OUT, 1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
